// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-write register file
//   state_t         : clear sequencer states (CLEAR, RUN)
//   abits_for()     : register address width for a given register count
//   port1_commit()  : write priority, port 2 wins an address collision
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEFAULT_DBITS = 32;
    localparam int DEFAULT_REGS  = 16;

    // A one-entry file would still need a one-bit address.
    function automatic int abits_for(input int regs);
        return (regs > 1) ? $clog2(regs) : 1;
    endfunction

    // Port 1 is dropped when port 2 writes the same register in the same cycle.
    function automatic logic port1_commit(input logic en1, input logic en2, input logic same_addr);
        return en1 && !(en2 && same_addr);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - post-reset clear sequencer for the register file
//   clk, reset      : clock, synchronous active-high reset
//   clrEn, clrAddr  : zero-write request onto the array write port
//   ready           : high once every entry has been cleared
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int REGS  = DEFAULT_REGS,
    parameter int ABITS = abits_for(REGS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             clrEn,
    output logic [ABITS-1:0] clrAddr,
    output logic             ready
);

    state_t           state;
    state_t           state_n;
    logic [ABITS-1:0] cnt;
    logic [ABITS-1:0] cnt_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // clrEn stays high while reset is held, so entry 0 is rewritten every cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clrEn   = 1'b0;
        clrAddr = cnt;
        ready   = 1'b0;
        case (state)
            CLEAR: begin
                clrEn = 1'b1;
                cnt_n = cnt + 1'b1;
                if (cnt == ABITS'(REGS - 1)) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: state_n = CLEAR;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - register file, two prioritised write ports, three combinational reads
//   Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding)
//   clk, reset                   : clock, synchronous active-high reset (starts clear)
//   wrtEn, wrtData               : write port 1, address rd
//   wrtEn2, wrtAddr2, wrtData2   : write port 2, wins collisions with port 1
//   rd, rs1, rs2                 : read addresses
//   outd, out1, out2             : read data, forced to 0 until ready
//   ready                        : clear finished, writes accepted
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DBITS    = DEFAULT_DBITS,
    parameter int REGS     = DEFAULT_REGS,
    parameter int ABITS    = abits_for(REGS),
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrtEn,
    input  logic [DBITS-1:0] wrtData,
    input  logic             wrtEn2,
    input  logic [ABITS-1:0] wrtAddr2,
    input  logic [DBITS-1:0] wrtData2,
    input  logic [ABITS-1:0] rd,
    input  logic [ABITS-1:0] rs1,
    input  logic [ABITS-1:0] rs2,
    output logic [DBITS-1:0] outd,
    output logic [DBITS-1:0] out1,
    output logic [DBITS-1:0] out2,
    output logic             ready
);

    logic [DBITS-1:0] regs [REGS];
    logic             clrEn;
    logic [ABITS-1:0] clrAddr;
    logic             run_we1;
    logic             run_we2;
    logic             we1;
    logic             we2;

    regfile_clear_seq #(
        .REGS  (REGS),
        .ABITS (ABITS)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .clrEn   (clrEn),
        .clrAddr (clrAddr),
        .ready   (ready)
    );

    // User writes are also blocked on the reset edge itself, while state may still be RUN.
    assign run_we1 = wrtEn  && ready && !reset && !((ZERO_REG != 0) && (rd == '0));
    assign run_we2 = wrtEn2 && ready && !reset && !((ZERO_REG != 0) && (wrtAddr2 == '0));
    assign we2     = run_we2;
    assign we1     = port1_commit(run_we1, run_we2, rd == wrtAddr2);

    // clrEn and ready are mutually exclusive, so the clear never races a user write.
    always_ff @(posedge clk) begin
        if (clrEn) begin
            regs[clrAddr] <= '0;
        end else begin
            if (we1) begin
                regs[rd] <= wrtData;
            end
            if (we2) begin
                regs[wrtAddr2] <= wrtData2;
            end
        end
    end

    function automatic logic [DBITS-1:0] read_port(input logic [ABITS-1:0] addr);
        logic [DBITS-1:0] val;
        val = regs[addr];
`ifdef REGFILE_BYPASS_EN
        // Port 2 is checked last so it wins a double match.
        if (we1 && (addr == rd)) begin
            val = wrtData;
        end
        if (we2 && (addr == wrtAddr2)) begin
            val = wrtData2;
        end
`endif
        if (!ready || ((ZERO_REG != 0) && (addr == '0))) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        outd = read_port(rd);
        out1 = read_port(rs1);
        out2 = read_port(rs2);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrtEn;
    logic [31:0] wrtData;
    logic        wrtEn2;
    logic [3:0]  wrtAddr2;
    logic [31:0] wrtData2;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] outd;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        ready;
    logic [31:0] outd_z;
    logic [31:0] out1_z;
    logic [31:0] out2_z;
    logic        ready_z;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DBITS(32), .REGS(16), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset),
        .wrtEn(wrtEn), .wrtData(wrtData),
        .wrtEn2(wrtEn2), .wrtAddr2(wrtAddr2), .wrtData2(wrtData2),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .outd(outd), .out1(out1), .out2(out2), .ready(ready)
    );

    regfile_mp #(.DBITS(32), .REGS(16), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset),
        .wrtEn(wrtEn), .wrtData(wrtData),
        .wrtEn2(wrtEn2), .wrtAddr2(wrtAddr2), .wrtData2(wrtData2),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .outd(outd_z), .out1(out1_z), .out2(out2_z), .ready(ready_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; wrtEn = 1'b0; wrtData = '0; wrtEn2 = 1'b0; wrtAddr2 = '0; wrtData2 = '0;
        rd = '0; rs1 = '0; rs2 = '0;

        // Reset state
        tick(); tick();
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_outd", outd, 32'h0);

        // First clear: writes to reg 2 during clear must be dropped
        reset = 1'b0;
        wrtEn = 1'b1; rd = 4'd2; wrtData = 32'h0000_1234; rs1 = 4'd2;
        for (int i = 0; i < 15; i++) tick();
        check("clr1_ready_at15", {31'b0, ready}, 32'h0);
        check("clr1_out1_forced", out1, 32'h0);
        wrtEn = 1'b0;
        tick();
        check("clr1_ready_at16", {31'b0, ready}, 32'h1);
        check("clr1_ready_z", {31'b0, ready_z}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            rs1 = 4'(i); #1;
            check($sformatf("clr1_zero_%0d", i), out1, 32'h0);
        end

        // Dual write, distinct addresses
        wrtEn = 1'b1; rd = 4'd3; wrtData = 32'hAAAA_0001;
        wrtEn2 = 1'b1; wrtAddr2 = 4'd7; wrtData2 = 32'h5555_0002;
        tick();
        wrtEn = 1'b0; wrtEn2 = 1'b0; rs1 = 4'd3; rs2 = 4'd7; rd = 4'd0; #1;
        check("dual_rs1", out1, 32'hAAAA_0001);
        check("dual_rs2", out2, 32'h5555_0002);
        check("dual_rs1_z", out1_z, 32'hAAAA_0001);

        // Write conflict on reg 5: port 2 wins
        wrtEn = 1'b1; rd = 4'd5; wrtData = 32'h11;
        wrtEn2 = 1'b1; wrtAddr2 = 4'd5; wrtData2 = 32'h22;
        tick();
        wrtEn = 1'b0; wrtEn2 = 1'b0; rs1 = 4'd5; #1;
        check("conflict_reg5", out1, 32'h22);

        // Read-during-write on reg 9 (currently 0)
        wrtEn = 1'b1; rd = 4'd9; wrtData = 32'h0000_DEAD; rs1 = 4'd9; #1;
`ifdef REGFILE_BYPASS_EN
        check("rdw_same_cycle", out1, 32'h0000_DEAD);
`else
        check("rdw_same_cycle", out1, 32'h0);
`endif
        tick();
        wrtEn = 1'b0; #1;
        check("rdw_next_cycle", out1, 32'h0000_DEAD);

        // Write 0xFFFF to address 0 on both ports
        wrtEn = 1'b1; rd = 4'd0; wrtData = 32'hFFFF;
        wrtEn2 = 1'b1; wrtAddr2 = 4'd0; wrtData2 = 32'hFFFF; rs1 = 4'd0; #1;
        check("zero_same_cycle_z", out1_z, 32'h0);
        tick();
        wrtEn = 1'b0; wrtEn2 = 1'b0; #1;
        check("zero_after_z", out1_z, 32'h0);
        check("zero_after_nozero", out1, 32'hFFFF);

        // Preload every entry, then reset and abort the clear at cnt = 6
        wrtEn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd = 4'(i); wrtData = 32'h100 + 32'(i);
            tick();
        end
        wrtEn = 1'b0; rs1 = 4'd15; rs2 = 4'd6; #1;
        check("preload_r15", out1, 32'h10F);
        check("preload_r6", out2, 32'h106);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("midclr_ready", {31'b0, ready}, 32'h0);
        check("midclr_out1_forced", out1, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("clr2_ready_at15", {31'b0, ready}, 32'h0);
        tick();
        check("clr2_ready_at16", {31'b0, ready}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            rs1 = 4'(i); #1;
            check($sformatf("clr2_zero_%0d", i), out1, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
